id_branch_unit: RTL and testbench
=================================

# id_branch_unit

Decode-stage control-flow unit: the consumer end of the fetch interface. It registers the PC and instruction presented by instruction fetch into the IF/ID pipeline register. It decodes jumps and branches and evaluates branch conditions against the register operands. It drives the redirect controls back to fetch: `jump_target`, `jump_branch`, `jump_reg`, `jr_pc`, `pc_id`, `instr_id`. It sits between instruction fetch / instruction ROM and the rest of decode.

## Interface
Parameters:
- `CNT_W`, 16: width of the taken-redirect counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  stage enable; low = stall (hold all state)
- `pc_if`  in  32  PC of the instruction currently returned by the ROM
- `instr_if`  in  32  instruction word at `pc_if`
- `rs_data`  in  32  forwarded rs value for the instruction in ID
- `rt_data`  in  32  forwarded rt value for the instruction in ID
- `pc_id`  out  32  registered PC of the ID instruction
- `instr_id`  out  32  registered instruction; fetch consumes bits [25:0]
- `valid_id`  out  1  ID slot holds a live instruction
- `jump_target`  out  1  J/JAL in ID
- `jump_branch`  out  1  taken conditional branch in ID
- `jump_reg`  out  1  JR/JALR in ID
- `jr_pc`  out  32  register jump target (= `rs_data`)
- `link_en`  out  1  ID instruction writes a return address
- `link_addr`  out  32  `pc_id + 8`
- `taken_cnt`  out  CNT_W  count of redirects accepted by fetch

## Operation
- **IF/ID register.**
  - On a rising edge with `en=1`: `pc_id<=pc_if`, `instr_id<=instr_if`, `valid_id<=1`.
  - With `en=0`: hold all of `pc_id`, `instr_id`, `valid_id`, `taken_cnt`.
- **Decode.** Opcode = `instr_id[31:26]`, rt = `[20:16]`, funct = `[5:0]`. All redirect outputs are gated by `valid_id`.
- **Jumps.**
  - `jump_target` for op `0x02` (J) and `0x03` (JAL).
  - `jump_reg` for op `0x00` with funct `0x08` (JR) or `0x09` (JALR).
- **Conditional branches** (`jump_branch` only when the condition is true; comparisons are 32-bit, signed where noted):
  - BEQ `0x04`: `rs==rt`
  - BNE `0x05`: `rs!=rt`
  - BLEZ `0x06`: `rs<=0` signed
  - BGTZ `0x07`: `rs>0` signed
  - REGIMM `0x01`:
    - rt=`0x00` BLTZ / rt=`0x10` BLTZAL: `rs<0`
    - rt=`0x01` BGEZ / rt=`0x11` BGEZAL: `rs>=0`
    - other rt values: no redirect.
- **Exclusivity.** At most one of `jump_target`/`jump_branch`/`jump_reg` is high in any cycle; this holds by opcode decode.
- **Outputs.**
  - `jr_pc=rs_data` always.
  - `link_en` for JAL, JALR, BLTZAL, BGEZAL. It is gated by `valid_id` and is asserted for the link-branches regardless of whether they are taken.
  - `link_addr=pc_id+32'd8`, modulo 2^32.
- **Taken counter.**
  - Increments by 1 on an edge with `en=1` and any redirect high.
  - Wraps from all-ones to 0.

## Timing
- **Reset values.** On an edge with `rst=1` (priority over `en`): `pc_id=0`, `instr_id=0` (NOP), `valid_id=0`, `taken_cnt=0`.
  - All decoded outputs are therefore 0.
  - `jr_pc` still follows `rs_data`; `link_addr=8`.
- **Latency.** Capture takes 1 cycle, IF→ID. Redirect outputs are combinational from the ID register and `rs_data`/`rt_data` in the same cycle.
- **Redirect handshake.** Fetch updates its PC at the same edge (`en=1`). The instruction captured at that edge is the delay slot (PC = `pc_id+4`). The redirect target is fetched the cycle after.
- **Stall.** With `en=0` and a redirect high, the outputs stay stable and high; the counter does not increment. The redirect is taken at the first edge with `en=1`.
- **Reset mid-operation.** A pending redirect is dropped. The next cycle shows NOP/invalid.

## Configuration
- `ID_DELAY_SLOT_SQUASH_EN`
  - **Defined:** at an edge with `en=1` and a redirect high, capture `instr_id<=0` and `valid_id<=0` (`pc_id` still captures `pc_if`). The delay-slot instruction is annulled.
  - **Undefined:** architectural MIPS delay slot; the delay-slot instruction is captured and executes normally.

## Test plan
- **Reset:** assert `rst` with `en=1` and `instr_if=0x08000010` → after the edge, `pc_id=0`, `instr_id=0`, `valid_id=0`, all redirect outputs 0, `taken_cnt=0`.
- **J:** `pc_if=0x100`, `instr_if=0x08000040` (J), `en=1` → next cycle `jump_target=1`, `instr_id[25:0]=0x40`. The following edge increments `taken_cnt` to 1.
- **BEQ taken / not taken:** `instr_id=0x10220003`.
  - `rs_data=rt_data=5` → `jump_branch=1`.
  - `rt_data=6` → `jump_branch=0`, counter unchanged.
- **Signed REGIMM:** BLTZAL (`0x04100002`) with `rs_data=0xFFFFFFFF` and `pc_id=0x200` → `jump_branch=1`, `link_en=1`, `link_addr=0x208`.
  - With `rs_data=0` → `jump_branch=0`, `link_en=1`.
- **JR under stall:** JR with `rs_data=0x00400020`, `en=0` for 3 cycles → `jump_reg=1`, `jr_pc=0x00400020` held; `taken_cnt` unchanged until `en=1`, then +1.
- **Delay slot:** J followed by `instr_if=0x24010001`.
  - Macro defined: next cycle `valid_id=0` and `instr_id=0`.
  - Macro undefined: `instr_id=0x24010001` and `valid_id=1`.

Source files
------------

// File: rtl/id_branch_unit.sv
// rtl/id_branch_unit.sv - IF/ID register, jump/branch decode and redirect generation for fetch
// Optional: ID_DELAY_SLOT_SQUASH_EN annuls the delay-slot instruction captured behind a redirect.
module id_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      pc_if,
  input  logic [31:0]      instr_if,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [31:0]      pc_id,
  output logic [31:0]      instr_id,
  output logic             valid_id,
  output logic             jump_target,
  output logic             jump_branch,
  output logic             jump_reg,
  output logic [31:0]      jr_pc,
  output logic             link_en,
  output logic [31:0]      link_addr,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  logic [5:0] opcode;
  logic [4:0] rt_field;
  logic [5:0] funct;
  logic       rs_neg;
  logic       rs_zero;
  logic       dec_jump;
  logic       dec_jreg;
  logic       dec_branch;
  logic       dec_link;
  logic       redirect;

  assign opcode   = instr_id[31:26];
  assign rt_field = instr_id[20:16];
  assign funct    = instr_id[5:0];
  assign rs_neg   = rs_data[31];
  assign rs_zero  = (rs_data == 32'd0);

  always_comb begin
    dec_jump   = 1'b0;
    dec_jreg   = 1'b0;
    dec_branch = 1'b0;
    dec_link   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        dec_jreg = (funct == FN_JR) || (funct == FN_JALR);
        dec_link = (funct == FN_JALR);
      end
      OP_REGIMM: begin
        // Link variants write $ra whether or not the branch is taken.
        case (rt_field)
          RT_BLTZ, RT_BLTZAL: dec_branch = rs_neg;
          RT_BGEZ, RT_BGEZAL: dec_branch = !rs_neg;
          default:            dec_branch = 1'b0;
        endcase
        dec_link = (rt_field == RT_BLTZAL) || (rt_field == RT_BGEZAL);
      end
      OP_J:    dec_jump = 1'b1;
      OP_JAL: begin
        dec_jump = 1'b1;
        dec_link = 1'b1;
      end
      OP_BEQ:  dec_branch = (rs_data == rt_data);
      OP_BNE:  dec_branch = (rs_data != rt_data);
      OP_BLEZ: dec_branch = rs_neg || rs_zero;
      OP_BGTZ: dec_branch = !rs_neg && !rs_zero;
      default: ;
    endcase
  end

  assign jump_target = valid_id && dec_jump;
  assign jump_branch = valid_id && dec_branch;
  assign jump_reg    = valid_id && dec_jreg;
  assign link_en     = valid_id && dec_link;
  assign jr_pc       = rs_data;
  assign link_addr   = pc_id + 32'd8;
  assign redirect    = jump_target || jump_branch || jump_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_id     <= 32'd0;
      instr_id  <= 32'd0;
      valid_id  <= 1'b0;
      taken_cnt <= '0;
    end else if (en) begin
      pc_id <= pc_if;
`ifdef ID_DELAY_SLOT_SQUASH_EN
      if (redirect) begin
        instr_id <= 32'd0;
        valid_id <= 1'b0;
      end else begin
        instr_id <= instr_if;
        valid_id <= 1'b1;
      end
`else
      instr_id <= instr_if;
      valid_id <= 1'b1;
`endif
      if (redirect) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_branch_unit.sv
// tb/tb_id_branch_unit.sv - scoreboard bench for id_branch_unit
module tb_id_branch_unit;

  localparam int CW = 4;
  localparam int VW = 133 + CW;
`ifdef ID_DELAY_SLOT_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  localparam logic [31:0] J_INSTR = 32'h08000040;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [31:0]   pc_if, instr_if, rs_data, rt_data;
  logic [31:0]   pc_id, instr_id, jr_pc, link_addr;
  logic          valid_id, jump_target, jump_branch, jump_reg, link_en;
  logic [CW-1:0] taken_cnt;

  typedef struct {
    string          name;
    logic [VW-1:0]  v;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        jt, jb, jr, lk;
  } vec_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] cnt_exp;
  logic          prev_red;

  always #5 clk = ~clk;

  id_branch_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_if(pc_if), .instr_if(instr_if),
    .rs_data(rs_data), .rt_data(rt_data), .pc_id(pc_id), .instr_id(instr_id),
    .valid_id(valid_id), .jump_target(jump_target), .jump_branch(jump_branch),
    .jump_reg(jump_reg), .jr_pc(jr_pc), .link_en(link_en), .link_addr(link_addr),
    .taken_cnt(taken_cnt)
  );

  function automatic logic [VW-1:0] observe();
    return {pc_id, instr_id, valid_id, jump_target, jump_branch, jump_reg, link_en,
            link_addr, jr_pc, taken_cnt};
  endfunction

  function automatic logic [VW-1:0] expv(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic v, input logic jt, input logic jb,
                                         input logic jr, input logic lk, input logic [CW-1:0] cnt);
    return {pc, instr, v, jt, jb, jr, lk, pc + 32'd8, rs_data, cnt};
  endfunction

  function automatic exp_t mk(input string name, input logic [VW-1:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pc_if = 32'h44; instr_if = 32'h08000010;
    rs_data = 32'h1234; rt_data = 32'h0;
    exp_q.push_back(mk("reset", expv(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    rst = 1'b0; cnt_exp = '0; prev_red = 1'b0;
  endtask

  task automatic test_jump_delay_slot();
    pc_if = 32'h100; instr_if = J_INSTR;
    exp_q.push_back(mk("j_capture", expv(32'h100, J_INSTR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    checks++;
    if (instr_id[25:0] !== 26'h40) begin
      errors++; $display("FAIL j_index actual=%h expected=%h", instr_id[25:0], 26'h40);
    end
    pc_if = 32'h104; instr_if = 32'h24010001; cnt_exp = cnt_exp + 1'b1;
    exp_q.push_back(mk("delay_slot", expv(32'h104, SQ ? 32'h0 : 32'h24010001, !SQ,
                                          1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
  endtask

  task automatic test_beq();
    pc_if = 32'h200; instr_if = 32'h10220003; rs_data = 32'd5; rt_data = 32'd5;
    exp_q.push_back(mk("beq_taken", expv(32'h200, 32'h10220003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    rt_data = 32'd6;
    exp_q.push_back(mk("beq_not_taken", expv(32'h200, 32'h10220003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    #1;
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    en = 1'b0; pc_if = 32'h204; instr_if = 32'h0;
    exp_q.push_back(mk("beq_stall_hold", expv(32'h200, 32'h10220003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    en = 1'b1;
    exp_q.push_back(mk("beq_nt_no_count", expv(32'h204, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
  endtask

  task automatic test_regimm();
    pc_if = 32'h200; instr_if = 32'h04100002; rs_data = 32'hFFFFFFFF; rt_data = 32'h0;
    exp_q.push_back(mk("bltzal_taken", expv(32'h200, 32'h04100002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    checks++;
    if (link_addr !== 32'h208) begin
      errors++; $display("FAIL bltzal_link_addr actual=%h expected=%h", link_addr, 32'h208);
    end
    rs_data = 32'h0;
    exp_q.push_back(mk("bltzal_not_taken", expv(32'h200, 32'h04100002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cnt_exp)));
    #1;
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    pc_if = 32'h204; instr_if = 32'h0;
    exp_q.push_back(mk("bltzal_nt_no_count", expv(32'h204, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
  endtask

  task automatic test_decode_table();
    vec_t tbl[15];
    logic [31:0] pc;
    logic        red;
    tbl[0]  = '{32'h14220003, 32'd5,        32'd6, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{32'h14220003, 32'd7,        32'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'h18200003, 32'd0,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'h18200003, 32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32'h18200003, 32'd1,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'h1C200003, 32'd1,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{32'h1C200003, 32'd0,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h1C200003, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h04200003, 32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32'h04200003, 32'd0,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h04310003, 32'd0,        32'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{32'h04310003, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{32'h04220003, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{32'h0020F809, 32'h00001000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{32'h0C000010, 32'h0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 15; i++) begin
      pc = 32'h300 + 32'(i * 8);
      pc_if = pc; instr_if = tbl[i].instr; rs_data = tbl[i].rs; rt_data = tbl[i].rt;
      exp_q.push_back(mk($sformatf("decode_%0d", i),
                         expv(pc, tbl[i].instr, 1'b1, tbl[i].jt, tbl[i].jb, tbl[i].jr, tbl[i].lk, cnt_exp)));
      tick();
      cur = exp_q.pop_front(); checks++;
      if (observe() !== cur.v) begin
        errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
      end
      red = tbl[i].jt || tbl[i].jb || tbl[i].jr;
      if (red) cnt_exp = cnt_exp + 1'b1;
      pc_if = pc + 32'd4; instr_if = 32'h0;
      exp_q.push_back(mk($sformatf("decode_%0d_slot", i),
                         expv(pc + 32'd4, 32'h0, !(SQ && red), 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
      tick();
      cur = exp_q.pop_front(); checks++;
      if (observe() !== cur.v) begin
        errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
      end
    end
  endtask

  task automatic test_jr_stall();
    pc_if = 32'h400; instr_if = 32'h00200008; rs_data = 32'h00400020; rt_data = 32'h0;
    exp_q.push_back(mk("jr_capture", expv(32'h400, 32'h00200008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    en = 1'b0; pc_if = 32'h404; instr_if = 32'h0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk($sformatf("jr_stall_%0d", k),
                         expv(32'h400, 32'h00200008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, cnt_exp)));
      tick();
      cur = exp_q.pop_front(); checks++;
      if (observe() !== cur.v) begin
        errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
      end
    end
    en = 1'b1; cnt_exp = cnt_exp + 1'b1;
    exp_q.push_back(mk("jr_release", expv(32'h404, 32'h0, !SQ, 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
  endtask

  task automatic test_back_to_back();
    logic sq;
    prev_red = 1'b0;
    instr_if = J_INSTR;
    for (int k = 0; k < 25; k++) begin
      if (prev_red) cnt_exp = cnt_exp + 1'b1;
      sq = SQ && prev_red;
      pc_if = 32'h500 + 32'(k * 4);
      exp_q.push_back(mk($sformatf("b2b_%0d", k),
                         expv(pc_if, sq ? 32'h0 : J_INSTR, !sq, !sq, 1'b0, 1'b0, 1'b0, cnt_exp)));
      tick();
      cur = exp_q.pop_front(); checks++;
      if (observe() !== cur.v) begin
        errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
      end
      prev_red = !sq;
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; en = 1'b1; pc_if = 32'h5F0; instr_if = J_INSTR;
    exp_q.push_back(mk("reset_mid", expv(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
    rst = 1'b0; pc_if = 32'h600; instr_if = 32'h0; cnt_exp = '0;
    exp_q.push_back(mk("after_reset", expv(32'h600, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt_exp)));
    tick();
    cur = exp_q.pop_front(); checks++;
    if (observe() !== cur.v) begin
      errors++; $display("FAIL %s actual=%h expected=%h", cur.name, observe(), cur.v);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc_if = '0; instr_if = '0; rs_data = '0; rt_data = '0;
    cnt_exp = '0; prev_red = 1'b0;
    test_reset();
    test_jump_delay_slot();
    test_beq();
    test_regimm();
    test_decode_table();
    test_jr_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
